// File: rtl/program_counter_pkg.sv
// Shared constants for the ternary program counter: word width, trit codes, FSM states.
package program_counter_pkg;

    localparam int WORD_SIZE = 9;

    // Unbalanced trit codes, two bits per trit, trit 0 in the LSBs.
    localparam logic [1:0] TRIT_0       = 2'b00;
    localparam logic [1:0] TRIT_1       = 2'b01;
    localparam logic [1:0] TRIT_2       = 2'b10;
    localparam logic [1:0] TRIT_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALTED  = 2'd3
    } pc_state_e;

endpackage

// File: rtl/program_counter_if.sv
// Control/status bundle between the sequencer core and the program counter.
import program_counter_pkg::*;

interface program_counter_if #(
    parameter int WORD_SIZE = program_counter_pkg::WORD_SIZE
);
    logic                   start;
    logic                   stall;
    logic                   exec_done;
    logic                   halt;
    logic                   branch_taken;
    logic [2*WORD_SIZE-1:0] branch_target;
    logic [2*WORD_SIZE-1:0] pc;
    logic                   fetch_enable;
    logic                   halted;
    logic                   trit_error;

    modport master (
        output start, stall, exec_done, halt, branch_taken, branch_target,
        input  pc, fetch_enable, halted, trit_error
    );

    modport slave (
        input  start, stall, exec_done, halt, branch_taken, branch_target,
        output pc, fetch_enable, halted, trit_error
    );
endinterface

// File: rtl/program_counter_ternary_incrementer.sv
// Combinational ternary +1, ripple carry from trit 0; all-2s wraps to all-0s with carry_out_o set.
// Zero latency, no handshake.
import program_counter_pkg::*;

module ternary_incrementer #(
    parameter int WORD_SIZE = program_counter_pkg::WORD_SIZE
) (
    input  logic [2*WORD_SIZE-1:0] value_i,
    output logic [2*WORD_SIZE-1:0] value_o,
    output logic                   carry_out_o
);

    logic       carry;
    logic [1:0] trit;

    always_comb begin
        value_o = value_i;
        carry   = 1'b1;
        trit    = TRIT_0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            trit = value_i[2*i +: 2];
            if (carry) begin
                case (trit)
                    TRIT_0:  begin value_o[2*i +: 2] = TRIT_1; carry = 1'b0; end
                    TRIT_1:  begin value_o[2*i +: 2] = TRIT_2; carry = 1'b0; end
                    TRIT_2:  begin value_o[2*i +: 2] = TRIT_0; carry = 1'b1; end
                    default: begin value_o[2*i +: 2] = trit;   carry = 1'b0; end
                endcase
            end
        end
        carry_out_o = carry;
    end

endmodule

// File: rtl/program_counter.sv
// Ternary program counter FSM (IDLE/FETCH/EXECUTE/HALTED); pc is registered and moves only on EXECUTE->FETCH.
// One-cycle state transitions; stall holds FETCH, exec_done gates EXECUTE.
import program_counter_pkg::*;

module program_counter #(
    parameter int WORD_SIZE = program_counter_pkg::WORD_SIZE
) (
    input  logic                    clock,
    input  logic                    reset_n,
    program_counter_if.slave        bus
);

    pc_state_e              state_q;
    logic [2*WORD_SIZE-1:0] pc_q;
    logic                   trit_error_q;

    logic [2*WORD_SIZE-1:0] pc_inc_d;
    logic                   inc_carry_unused;
    logic                   target_bad;

    ternary_incrementer #(.WORD_SIZE(WORD_SIZE)) u_inc (
        .value_i     (pc_q),
        .value_o     (pc_inc_d),
        .carry_out_o (inc_carry_unused)
    );

    always_comb begin
        target_bad = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (bus.branch_target[2*i +: 2] == TRIT_INVALID) target_bad = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            trit_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!bus.stall) state_q <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (bus.exec_done) begin
                        if (bus.halt) begin
                            state_q <= ST_HALTED;
                        end else if (bus.branch_taken) begin
                            // A corrupt target stops the core instead of jumping somewhere undefined.
                            if (target_bad) begin
                                trit_error_q <= 1'b1;
                                state_q      <= ST_HALTED;
                            end else begin
                                pc_q    <= bus.branch_target;
                                state_q <= ST_FETCH;
                            end
                        end else begin
                            pc_q    <= pc_inc_d;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.fetch_enable = (state_q == ST_FETCH);
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.trit_error   = trit_error_q;

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL take parameter WORD_SIZE, default 9 (from parameters.vh), word width in trits; every ternary bus is 2*WORD_SIZE bits, 2 bits per trit.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port stall  input  1  hold in FETCH while memory is not ready.
REQ-006 SHALL have port exec_done  input  1  current instruction finished; PC may advance.
REQ-007 SHALL have port halt  input  1  sampled with exec_done; stop the processor.
REQ-008 SHALL have port branch_taken  input  1  sampled with exec_done; load branch_target.
REQ-009 SHALL have port branch_target  input  2*WORD_SIZE  ternary address for a taken branch.
REQ-010 SHALL have port pc  output  2*WORD_SIZE  instruction memory address, registered.
REQ-011 SHALL have port fetch_enable  output  1  drives the fetch stage's fetch_enable.
REQ-012 SHALL have port halted  output  1  high in HALTED state.
REQ-013 SHALL have port trit_error  output  1  sticky; an invalid trit code was seen on branch_target.

Function
REQ-014 SHALL use unbalanced trit encoding 00=0, 01=1, 10=2; 11 is invalid; trit 0 occupies bits [1:0].
REQ-015 SHALL implement FSM states IDLE, FETCH, EXECUTE, HALTED.
REQ-016 IDLE: fetch_enable=0; start=1 -> FETCH next cycle; otherwise stay.
REQ-017 FETCH: fetch_enable=1 (decoded from state, same cycle); stall=1 -> stay in FETCH; stall=0 -> EXECUTE next cycle.
REQ-018 EXECUTE: fetch_enable=0; pc held; exec_done=0 -> stay.
REQ-019 On exec_done=1 in EXECUTE, priority SHALL be halt > branch_taken > increment.
REQ-020 halt=1: -> HALTED; pc unchanged.
REQ-021 branch_taken=1 with all trits valid: pc <= branch_target; -> FETCH.
REQ-022 branch_taken=1 with any trit = 11: pc unchanged; trit_error <= 1; -> HALTED.
REQ-023 Otherwise pc <= pc+1 in ternary, ripple carry from trit 0 (2+1 -> 0, carry 1); -> FETCH.
REQ-024 Increment of all-2s SHALL wrap to all-0s with no flag.
REQ-025 HALTED: fetch_enable=0, halted=1; all inputs ignored; exit only via reset.
REQ-026 start, stall, exec_done, halt and branch_taken SHALL be ignored in any state where they are not listed above.
REQ-027 pc SHALL change only on an EXECUTE->FETCH transition, so the fetched instruction is stable for all of EXECUTE.

Reset
REQ-028 reset_n low SHALL immediately force state=IDLE, pc=all 00, fetch_enable=0, halted=0, trit_error=0, in any state including mid-FETCH/EXECUTE.
REQ-029 After reset_n is released, the first start SHALL fetch from address 0.

Structure
REQ-030 WORD_SIZE, trit code constants (TRIT_0/1/2, TRIT_INVALID) and FSM state encodings SHALL live in parameters.vh.
REQ-031 Ternary +1 SHALL be a combinational sub-module ternary_incrementer (input/output 2*WORD_SIZE bits, carry_out), reusable by the ALU.
REQ-032 pc, state and trit_error SHALL be the only registers.

Verification (WORD_SIZE=9; trit strings MSB..LSB)
REQ-033 Reset, start pulse -> FETCH next cycle, fetch_enable=1 one cycle, pc=000000000.
REQ-034 pc=000000022, exec_done -> pc=000000100 (carry ripple); then pc=222222222, exec_done -> pc=000000000 (wrap).
REQ-035 stall held 3 cycles in FETCH -> fetch_enable high 4 cycles, pc constant, then EXECUTE.
REQ-036 exec_done with branch_taken=1, target=000120201 -> pc=000120201; same with halt=1 also set -> HALTED, pc unchanged.
REQ-037 branch_target with trit 4 = 11 -> trit_error=1, halted=1, pc unchanged; later start ignored.
REQ-038 reset_n asserted mid-EXECUTE at pc=000000012 -> outputs zero immediately, IDLE; next start fetches pc=0.
